// File: rtl/vblank_update_scheduler_if.sv
// vblank_update_scheduler_if: req/done/gnt/busy handshake between update clients and the scheduler.
interface vblank_update_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    modport master (output req, done, input gnt, busy);
    modport slave (input req, done, output gnt, busy);
endinterface

// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler: round-robin update-slot arbiter confined to vertical blank, plus frame tick/counter.
// Define SCHED_WATCHDOG_EN to revoke grants held for TIMEOUT_CYC cycles without done.
module vblank_update_scheduler #(
    parameter int N_REQ       = 4,
    parameter int FRAME_W     = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic                     vblnk,
    vblank_update_scheduler_if.slave bus,
    output logic                     frame_tick,
    output logic [FRAME_W-1:0]       frame_cnt,
    output logic                     overrun,
    output logic                     timeout
);
    localparam int PW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;
    state_t state_q, state_d;
    logic vblnk_q, rise, fall, found, owner_done, wd_hit, retire;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick, owner_nxt;
    logic [N_REQ-1:0] served_q, served_d, gnt_q, gnt_d, eligible;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic frame_tick_q, frame_tick_d, overrun_q, overrun_d, timeout_q, timeout_d, busy_q;

    assign rise       = vblnk & ~vblnk_q;
    assign fall       = ~vblnk & vblnk_q;
    assign eligible   = bus.req & ~served_q;
    assign found      = |eligible;
    assign owner_done = state_q == GRANT && bus.done[owner_q];
    assign owner_nxt  = owner_q == PW'(N_REQ - 1) ? '0 : owner_q + 1'b1;

`ifdef SCHED_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYC) + 1;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    assign wd_cnt_d = state_q == GRANT ? wd_cnt_q + 1'b1 : '0;
    assign wd_hit   = state_q == GRANT && wd_cnt_q == WW'(TIMEOUT_CYC - 1);
    always_ff @(posedge pclk or posedge rst)
        if (rst) wd_cnt_q <= '0;
        else wd_cnt_q <= wd_cnt_d;
`else
    assign wd_hit = 1'b0;
`endif

    // Lowest eligible index overall, overridden by the lowest one at or after rr_ptr.
    always_comb begin
        pick = rr_ptr_q;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (eligible[i]) pick = PW'(i);
        for (int i = N_REQ - 1; i >= 0; i--)
            if (eligible[i] && PW'(i) >= rr_ptr_q) pick = PW'(i);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rise ? ARB : IDLE;
            ARB:     state_d = fall ? IDLE : found ? GRANT : ARB;
            GRANT:   state_d = fall ? IDLE : (owner_done || wd_hit) ? ARB : GRANT;
            default: state_d = IDLE;
        endcase
    end

    // A watchdog hit coinciding with window close is reported as an overrun instead.
    always_comb begin
        retire       = state_q == GRANT && (owner_done || (wd_hit && !fall));
        frame_tick_d = state_q == IDLE && rise;
        frame_cnt_d  = frame_tick_d ? frame_cnt_q + 1'b1 : frame_cnt_q;
        served_d     = frame_tick_d ? '0 : served_q;
        if (retire) served_d[owner_q] = 1'b1;
        rr_ptr_d     = retire ? owner_nxt : rr_ptr_q;
        owner_d      = state_q == ARB ? pick : owner_q;
        gnt_d        = state_q == ARB && found && !fall ? N_REQ'(1) << pick
                     : state_q == GRANT && state_d == GRANT ? gnt_q : '0;
        overrun_d    = state_q == GRANT && fall && !owner_done;
        timeout_d    = state_q == GRANT && wd_hit && !owner_done && !fall;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vblnk_q      <= 1'b0;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            served_q     <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            vblnk_q      <= vblnk;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            served_q     <= served_d;
            gnt_q        <= gnt_d;
            busy_q       <= |gnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.busy   = busy_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_vblank_update_scheduler.sv
// tb_vblank_update_scheduler: directed and randomized windows checked every cycle against a
// frame-level reference model of the round-robin vblank scheduler.
module tb_vblank_update_scheduler;
    localparam int N  = 4;
    localparam int FW = 4;
    localparam int TO = 16;
    logic pclk  = 1'b0;
    logic rst   = 1'b1;
    logic vblnk = 1'b0;
    logic frame_tick, overrun, timeout;
    logic [FW-1:0] frame_cnt;
    int n_checks = 0;
    int n_fail   = 0;
    int m_state, m_rr, m_owner, m_age, m_frames;
    bit m_vq, m_tick, m_over, m_to;
    bit m_served [N];
    int lat [N];
    bit noise;
    int dut_order [$];
    logic [N-1:0] prev_gnt;
    int n_over, n_to, gnt1_cyc;

    vblank_update_scheduler_if #(.N_REQ(N)) bus ();

    vblank_update_scheduler #(.N_REQ(N), .FRAME_W(FW), .TIMEOUT_CYC(TO)) dut (
        .pclk(pclk), .rst(rst), .vblnk(vblnk), .bus(bus),
        .frame_tick(frame_tick), .frame_cnt(frame_cnt), .overrun(overrun), .timeout(timeout)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_order(input string tag, input int exp [$]);
        chk({tag, "_count"}, dut_order.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_order.size(); i++) chk(tag, dut_order[i], exp[i]);
    endtask

    task automatic model_reset();
        m_state = 0; m_rr = 0; m_owner = -1; m_age = 0; m_frames = 0;
        m_vq = 0; m_tick = 0; m_over = 0; m_to = 0;
        foreach (m_served[i]) m_served[i] = 0;
        prev_gnt = '0;
    endtask

    // Window-level rules: 0 = outside window, 1 = window open with slot free, 2 = slot owned.
    task automatic model_step();
        bit rise, fall, odone, wd;
        rise = vblnk && !m_vq;
        fall = !vblnk && m_vq;
        m_vq = vblnk;
        m_tick = 0; m_over = 0; m_to = 0;
        if (m_state == 0) begin
            if (rise) begin
                m_tick = 1;
                m_frames = (m_frames + 1) % (1 << FW);
                foreach (m_served[i]) m_served[i] = 0;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (fall) m_state = 0;
            else for (int k = 0; k < N; k++) begin
                int idx = (m_rr + k) % N;
                if (m_state == 1 && bus.req[idx] && !m_served[idx]) begin
                    m_owner = idx; m_age = 0; m_state = 2;
                end
            end
        end else begin
            odone = bus.done[m_owner];
`ifdef SCHED_WATCHDOG_EN
            wd = m_age == TO - 1;
`else
            wd = 0;
`endif
            if (odone || (wd && !fall)) begin
                m_served[m_owner] = 1;
                m_rr = (m_owner + 1) % N;
                m_to = !odone;
                m_owner = -1;
                m_state = fall ? 0 : 1;
            end else if (fall) begin
                m_over = 1; m_owner = -1; m_state = 0;
            end else m_age++;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] d;
        logic [31:0] eg;
        d = noise ? N'($urandom) : '0;
        if (m_state == 2) d[m_owner] = lat[m_owner] >= 0 && m_age == lat[m_owner];
        bus.done = d;
        model_step();
        @(posedge pclk);
        @(negedge pclk);
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("gnt", bus.gnt, eg);
        chk("busy", bus.busy, m_owner >= 0);
        chk("frame_tick", frame_tick, m_tick);
        chk("frame_cnt", frame_cnt, m_frames);
        chk("overrun", overrun, m_over);
        chk("timeout", timeout, m_to);
        if (bus.gnt != 0 && prev_gnt == 0)
            for (int i = 0; i < N; i++) if (bus.gnt[i]) dut_order.push_back(i);
        prev_gnt = bus.gnt;
        n_over += overrun;
        n_to += timeout;
        gnt1_cyc += bus.gnt[1];
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic open_win(input logic [N-1:0] r);
        bus.req = r;
        dut_order.delete();
        vblnk = 1'b1;
        cycle();
    endtask

    task automatic close_win();
        vblnk = 1'b0;
        cycle();
    endtask

    initial begin
        bus.req = '0; bus.done = '0; noise = 0;
        n_over = 0; n_to = 0; gnt1_cyc = 0;
        foreach (lat[i]) lat[i] = 3;
        model_reset();
        repeat (2) @(negedge pclk);
        chk("reset_gnt", bus.gnt, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_tick", frame_tick, 0);
        chk("reset_cnt", frame_cnt, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_timeout", timeout, 0);
        rst = 1'b0;
        cycle();
        open_win('0);
        chk("tick_first", frame_tick, 1);
        chk("cnt_first", frame_cnt, 1);
        cycle();
        chk("tick_once", frame_tick, 0);
        chk("gnt_noreq", bus.gnt, 0);
        bus.req = 4'b1111;
        run(30);
        chk_order("w1_order", '{0, 1, 2, 3});
        close_win();
        run(3);
        open_win(4'b0011);
        run(15);
        chk_order("w2_order", '{0, 1});
        close_win();
        run(2);
        open_win(4'b1010);
        run(15);
        chk_order("w3_order", '{3, 1});
        bus.req = 4'b1011;
        cycle();
        chk("late_req0", bus.gnt, 4'b0001);
        run(6);
        close_win();
        run(2);
        lat[1] = 2; lat[2] = -1;
        open_win(4'b0110);
        run(12);
        chk_order("w4_order", '{1, 2});
        close_win();
        chk("overrun_pulse", overrun, 1);
        chk("overrun_gnt", bus.gnt, 0);
        cycle();
        chk("overrun_once", overrun, 0);
        run(2);
        foreach (lat[i]) lat[i] = 2;
        open_win(4'b1101);
        run(25);
        chk_order("w5_after_overrun", '{2, 3, 0});
        close_win();
        run(2);
        lat[1] = -1; lat[2] = 2;
        n_over = 0; n_to = 0; gnt1_cyc = 0;
        open_win(4'b0110);
        run(40);
        close_win();
        run(2);
`ifdef SCHED_WATCHDOG_EN
        chk_order("wd_order", '{1, 2});
        chk("wd_gnt1_cycles", gnt1_cyc, TO);
        chk("wd_timeouts", n_to, 1);
        chk("wd_overruns", n_over, 0);
`else
        chk_order("hold_order", '{1});
        chk("hold_gnt1_cycles", gnt1_cyc, 40);
        chk("hold_timeouts", n_to, 0);
        chk("hold_overruns", n_over, 1);
`endif
        foreach (lat[i]) lat[i] = 5;
        open_win(4'b1111);
        run(3);
        #2;
        rst = 1'b1;
        vblnk = 1'b0;
        #1;
        chk("rst_async_gnt", bus.gnt, 0);
        chk("rst_async_busy", bus.busy, 0);
        @(negedge pclk);
        rst = 1'b0;
        model_reset();
        chk("rst_cnt", frame_cnt, 0);
        foreach (lat[i]) lat[i] = 1;
        open_win(4'b1111);
        run(20);
        chk_order("post_rst_order", '{0, 1, 2, 3});
        close_win();
        run(2);
        noise = 1;
        for (int w = 0; w < 20; w++) begin
            int len;
            foreach (lat[i]) lat[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            len = $urandom_range(5, 60);
            open_win(N'($urandom));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 7) == 0) bus.req = N'($urandom);
                cycle();
            end
            close_win();
            repeat ($urandom_range(1, 5)) begin
                bus.req = N'($urandom);
                cycle();
            end
        end
        noise = 0;
        bus.req = '0;
        for (int g = 0; g < 40 && m_frames != (1 << FW) - 1; g++) begin
            open_win('0);
            run(2);
            close_win();
            cycle();
        end
        chk("pre_wrap_cnt", frame_cnt, (1 << FW) - 1);
        open_win('0);
        chk("wrap_cnt", frame_cnt, 0);
        chk("wrap_tick", frame_tick, 1);
        run(2);
        close_win();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
